// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared register, load and writeback-state types for the writeback stage
package wb_stage_pkg;
    localparam int Data_Bus = 32;
    localparam logic [Data_Bus-1:0] Zero_Word = '0;
    typedef enum logic [4:0] {
        REG_ZERO, REG_AT, REG_V0, REG_V1, REG_A0, REG_A1, REG_A2, REG_A3,
        REG_T0, REG_T1, REG_T2, REG_T3, REG_T4, REG_T5, REG_T6, REG_T7,
        REG_S0, REG_S1, REG_S2, REG_S3, REG_S4, REG_S5, REG_S6, REG_S7,
        REG_T8, REG_T9, REG_K0, REG_K1, REG_GP, REG_SP, REG_FP, REG_RA
    } reg_enum;
    typedef enum logic [2:0] {LB, LBU, LH, LHU, LW} load_enum;
    typedef enum logic [1:0] {IDLE, WAIT_DATA, DRAIN, WRITE} wb_state;
endpackage

// File: rtl/wb_stage_load_ext.sv
// load_ext: selects the byte/half lane of a read word and sign- or zero-extends it
module load_ext import wb_stage_pkg::*; #(
    parameter int Data_Bus = 32
) (
    input  load_enum            load_type,
    input  logic [1:0]          addr_low,
    input  logic [Data_Bus-1:0] rdata,
    output logic [Data_Bus-1:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    // pick the addressed lane, then extend according to the load type
    always_comb begin
        b = rdata[{addr_low, 3'b000} +: 8];
        h = addr_low[1] ? rdata[31:16] : rdata[15:0];
        data = load_type == LB  ? {{(Data_Bus-8){b[7]}}, b} :
               load_type == LBU ? {{(Data_Bus-8){1'b0}}, b} :
               load_type == LH  ? {{(Data_Bus-16){h[15]}}, h} :
               load_type == LHU ? {{(Data_Bus-16){1'b0}}, h} : rdata;
    end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage that retires results, waits for load data and honours flushes
module wb_stage import wb_stage_pkg::*; #(
    parameter int Data_Bus = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic                mem_wen,
    input  reg_enum             mem_waddr,
    input  logic [Data_Bus-1:0] mem_result,
    input  logic                mem_is_load,
    input  load_enum            mem_load_type,
    input  logic [1:0]          mem_addr_low,
    input  logic [31:0]         mem_pc,
    input  logic                data_ok,
    input  logic [Data_Bus-1:0] data_rdata,
    input  logic                flush,
    output logic                wregs_Enable,
    output reg_enum             wregsAddr,
    output logic [Data_Bus-1:0] wdata,
    output reg_enum             wb_pending_addr,
    output logic                wb_pending,
    output logic [31:0]         debug_wb_pc,
    output logic [3:0]          debug_wb_rf_wen,
    output reg_enum             debug_wb_rf_wnum,
    output logic [Data_Bus-1:0] debug_wb_rf_wdata
);
    wb_state             state_q, state_d;
    logic                wen_q;
    reg_enum             waddr_q;
    load_enum            type_q;
    logic [1:0]          addr_low_q;
    logic [31:0]         pc_q;
    logic [Data_Bus-1:0] data_q, ext_data;
    logic                accept;

    load_ext #(.Data_Bus(Data_Bus)) u_load_ext (
        .load_type(type_q),
        .addr_low (addr_low_q),
        .rdata    (data_rdata),
        .data     (ext_data)
    );

    assign mem_ready = ~flush & (state_q == IDLE || state_q == WRITE);
    assign accept    = mem_valid & mem_ready;

    // next state: a flushed load either drops its data now or drains the late response
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, WRITE: state_d = accept ? (mem_is_load ? WAIT_DATA : WRITE) : IDLE;
            WAIT_DATA:   state_d = flush ? (data_ok ? IDLE : DRAIN) : (data_ok ? WRITE : WAIT_DATA);
            DRAIN:       state_d = data_ok ? IDLE : DRAIN;
            default:     state_d = IDLE;
        endcase
    end

    // state register plus the instruction payload latched on acceptance or load return
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wen_q      <= 1'b0;
            waddr_q    <= REG_ZERO;
            type_q     <= LB;
            addr_low_q <= 2'b00;
            pc_q       <= '0;
            data_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wen_q      <= mem_wen;
                waddr_q    <= mem_waddr;
                type_q     <= mem_load_type;
                addr_low_q <= mem_addr_low;
                pc_q       <= mem_pc;
                data_q     <= mem_result;
            end else if (state_q == WAIT_DATA && data_ok && !flush) begin
                data_q <= ext_data;
            end
        end
    end

    assign wregs_Enable      = state_q == WRITE && wen_q && waddr_q != REG_ZERO;
    assign wregsAddr         = wregs_Enable ? waddr_q : REG_ZERO;
    assign wdata             = wregs_Enable ? data_q : '0;
    assign wb_pending        = state_q == WAIT_DATA;
    assign wb_pending_addr   = wb_pending ? waddr_q : REG_ZERO;
    assign debug_wb_pc       = wregs_Enable ? pc_q : 32'd0;
    assign debug_wb_rf_wen   = {4{wregs_Enable}};
    assign debug_wb_rf_wnum  = wregsAddr;
    assign debug_wb_rf_wdata = wdata;
endmodule
